pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It replaces the fixed-field, stall/clear-driven inter-stage registers such as decode→execute. Fields are packed into one `DATA_W` bus by the surrounding stage. A flushed or empty slot presents a programmable bubble (`NOP_DATA`) on the output. Backpressure is registered, so there is no combinational path from `out_ready` to `in_ready`, and full throughput is kept under back-to-back traffic.

---
 rtl/pipe_skid_reg.sv | 83 ++++++++
 tb/tb_pipe_skid_reg.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer and synchronous flush; one cycle in-to-out latency.
// in_ready is taken straight from the skid-valid register, so backpressure never forms a combinational path.
module pipe_skid_reg #(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              main_vld_q, main_vld_d;
   logic [DATA_W-1:0] main_dat_q, main_dat_d;
   logic              skid_vld_q, skid_vld_d;
   logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
   logic [1:0]        occ_q, occ_d;
   logic              accept;
   logic              emit;

   assign accept = in_valid & ~skid_vld_q;
   assign emit   = main_vld_q & out_ready;

   always_comb begin
      main_vld_d = main_vld_q;
      main_dat_d = main_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (flush) begin
         main_vld_d = 1'b0;
         main_dat_d = NOP_DATA;
         skid_vld_d = 1'b0;
      end else if (!main_vld_q) begin
         if (accept) begin
            main_vld_d = 1'b1;
            main_dat_d = in_data;
         end
      end else if (emit) begin
         if (skid_vld_q) begin
            main_dat_d = skid_dat_q;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_dat_d = in_data;
         end else begin
            // main_dat must fall back to the bubble so out_data needs no output mux
            main_vld_d = 1'b0;
            main_dat_d = NOP_DATA;
         end
      end else if (accept) begin
         skid_vld_d = 1'b1;
         skid_dat_d = in_data;
      end
      occ_d = {1'b0, main_vld_d} + {1'b0, skid_vld_d};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_vld_q <= 1'b0;
         main_dat_q <= NOP_DATA;
         skid_vld_q <= 1'b0;
         skid_dat_q <= NOP_DATA;
         occ_q      <= 2'd0;
      end else begin
         main_vld_q <= main_vld_d;
         main_dat_q <= main_dat_d;
         skid_vld_q <= skid_vld_d;
         skid_dat_q <= skid_dat_d;
         occ_q      <= occ_d;
      end
   end

   assign in_ready  = ~skid_vld_q;
   assign out_valid = main_vld_q;
   assign out_data  = main_dat_q;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic, checked against a queue model of the stage.
module tb_pipe_skid_reg;
   localparam int         DW  = 8;
   localparam logic [7:0] NOP = 8'h13;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   int errs   = 0;
   int checks = 0;

   // Payloads currently held by the stage, oldest first; at most two.
   logic [DW-1:0] sb_q[$];

   pipe_skid_reg #(.DATA_W(DW), .NOP_DATA(NOP)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int live;
      live = sb_q.size();
      chk("out_valid", out_valid, live > 0);
      chk("in_ready",  in_ready,  live < 2);
      chk("occupancy", occupancy, live);
      chk("out_data",  out_data,  (live > 0) ? sb_q[0] : NOP);
   endtask

   // Predicts the effect of the coming rising edge from the inputs now held stable.
   task automatic model_step();
      bit acc, emt;
      if (!rst) begin
         sb_q.delete();
         return;
      end
      emt = (sb_q.size() > 0) && out_ready;
      acc = in_valid && (sb_q.size() < 2);
      if (emt) void'(sb_q.pop_front());
      if (flush) sb_q.delete();
      else if (acc) sb_q.push_back(in_data);
   endtask

   // Called just after a rising edge: drive, check mid-cycle, update model, move to the next edge.
   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit ordy, input bit fl);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      if (!rst) sb_q.delete();
      @(negedge clk);
      check_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      // Reset held with random inputs, including flush.
      for (int i = 0; i < 4; i++)
         cycle($urandom_range(0, 1), DW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));

      rst = 1'b1;
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Streaming at full rate.
      for (int i = 1; i <= 16; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Backpressure into skid, then drain without gaps.
      cycle(1'b1, 8'h01, 1'b1, 1'b0);
      cycle(1'b1, 8'h02, 1'b0, 1'b0);
      cycle(1'b1, 8'h03, 1'b0, 1'b0);
      cycle(1'b1, 8'h03, 1'b0, 1'b0);
      cycle(1'b1, 8'h03, 1'b1, 1'b0);
      cycle(1'b1, 8'h03, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Flush while full, with a same-cycle input that must be dropped.
      cycle(1'b1, 8'h07, 1'b0, 1'b0);
      cycle(1'b1, 8'h08, 1'b0, 1'b0);
      cycle(1'b1, 8'h09, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Emit coinciding with flush.
      cycle(1'b1, 8'h04, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset pulse between edges while full.
      cycle(1'b1, 8'h21, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      in_valid = 1'b0;
      chk("occ_before_arst", occupancy, 2);
      #1 rst = 1'b0;
      #1;
      sb_q.delete();
      check_outputs();
      #1 rst = 1'b1;
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) != 0);
         cycle($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6,
               $urandom_range(0, 49) == 0);
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
